// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps a decoder select code upward through the unmasked
// codes, holding each for dwell+1 cycles, once (single-shot) or repeatedly.
module decoder_scan_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic [2**SEL_W-1:0]   skip_mask,
    output logic [SEL_W-1:0]      i,
    output logic                  i_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);
    localparam int N = 2**SEL_W;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [SEL_W-1:0]   i_q, i_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic [N-1:0]       mask_q, mask_d;
    logic               cont_q, cont_d, done_q, done_d, wrap_q, wrap_d;
    logic [SEL_W:0]     lo_hit, wrap_hit, nxt_hit;

    // {found, code}: lowest unmasked code at or above lo
    function automatic logic [SEL_W:0] first_free(input logic [N-1:0] m, input int lo);
        first_free = '0;
        for (int k = N - 1; k >= 0; k--)
            if (!m[k] && k >= lo) first_free = {1'b1, SEL_W'(k)};
    endfunction

    assign lo_hit   = first_free(skip_mask, 0);
    assign wrap_hit = first_free(mask_q, 0);
    assign nxt_hit  = first_free(mask_q, int'(i_q) + 1);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start && !stop) begin
                if (lo_hit[SEL_W]) begin
                    state_d = RUN;
                    i_d     = lo_hit[SEL_W-1:0];
                    cnt_d   = '0;
                    dwell_d = dwell;
                    mask_d  = skip_mask;
                    cont_d  = continuous;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (stop) begin
            state_d = IDLE;
        end else if (cnt_q != dwell_q) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if (nxt_hit[SEL_W]) begin
                i_d = nxt_hit[SEL_W-1:0];
            end else if (cont_q) begin
                i_d    = wrap_hit[SEL_W-1:0];
                wrap_d = 1'b1;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign i       = i_q;
    assign i_valid = state_q == RUN;
    assign busy    = state_q == RUN;
    assign done    = done_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed scenarios plus random traffic, checked every
// cycle against a sweep-schedule model of the sequencer.
module tb_decoder_scan_sequencer;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst, start, stop, continuous;
    logic [7:0] dwell, skip_mask;
    logic [2:0] i;
    logic       i_valid, busy, done, wrap;
    logic [6:0] outs;

    int vectors = 0;
    int errors  = 0;

    decoder_scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .dwell(dwell), .skip_mask(skip_mask), .i(i), .i_valid(i_valid),
        .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    assign outs = {i, i_valid, busy, done, wrap};

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {i,valid,busy,done,wrap}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is a list of unmasked codes; cycle t of the sweep shows
    // code list[(t/period) % n], and the sweep length is n*period cycles.
    bit         chk_on = 1'b0;
    bit         m_run = 1'b0, m_cont, e_done, e_wrap;
    int         m_list[$];
    int         m_per, m_t;
    logic [2:0] m_i;

    always @(posedge clk) begin
        e_done = 1'b0;
        e_wrap = 1'b0;
        if (rst) begin
            m_run  = 1'b0;
            m_i    = 3'd0;
            chk_on = 1'b1;
        end else if (m_run) begin
            if (stop) m_run = 1'b0;
            else begin
                m_t++;
                if (!m_cont && m_t == m_list.size() * m_per) begin
                    m_run  = 1'b0;
                    e_done = 1'b1;
                end
            end
        end else if (start && !stop) begin
            m_list.delete();
            for (int k = 0; k < N; k++) if (!skip_mask[k]) m_list.push_back(k);
            if (m_list.size() == 0) e_done = 1'b1;
            else begin
                m_run  = 1'b1;
                m_t    = 0;
                m_per  = int'(dwell) + 1;
                m_cont = continuous;
            end
        end
        if (m_run) begin
            m_i    = 3'(m_list[(m_t / m_per) % m_list.size()]);
            e_wrap = m_cont && m_t > 0 && (m_t % (m_list.size() * m_per)) == 0;
        end
    end

    always @(negedge clk)
        if (chk_on) chk("model", outs, {m_i, m_run, m_run, e_done, e_wrap});

    task automatic go(input logic c, input logic [7:0] d, input logic [7:0] m);
        continuous = c;
        dwell      = d;
        skip_mask  = m;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int codes[4] = '{1, 3, 4, 6};
        logic w;
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; dwell = '0; skip_mask = '0;
        repeat (2) @(negedge clk);
        chk("reset", outs, 7'b0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle", outs, 7'b0);
        end
        // Full ascending sweep, one code per cycle
        go(1'b0, 8'd0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            chk("t2 step", outs, {3'(k), 4'b1100});
            @(negedge clk);
        end
        chk("t2 done", outs, {3'd7, 4'b0010});
        @(negedge clk);
        // Masked sweep with a 3-cycle dwell
        go(1'b0, 8'd2, 8'hA5);
        foreach (codes[c])
            repeat (3) begin
                chk("t3 step", outs, {3'(codes[c]), 4'b1100});
                @(negedge clk);
            end
        chk("t3 done", outs, {3'd6, 4'b0010});
        @(negedge clk);
        // Continuous, single code: wrap every 2 cycles, then stop
        go(1'b1, 8'd1, 8'hFE);
        for (int t = 0; t < 6; t++) begin
            w = t > 0 && t % 2 == 0;
            chk("t4 wrap", outs, {3'd0, 3'b110, w});
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t4 stop", outs, {3'd0, 4'b0000});
        // All masked: immediate done; then start+stop together
        go(1'b0, 8'd0, 8'hFF);
        chk("t5 allmask", outs, {3'd0, 4'b0010});
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("t5 startstop", outs, {3'd0, 4'b0000});
        // Reset mid-dwell, then restart from the lowest unmasked code
        go(1'b0, 8'd3, 8'h00);
        repeat (21) @(negedge clk);
        chk("t6 mid", outs, {3'd5, 4'b1100});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6 reset", outs, 7'b0);
        go(1'b0, 8'd0, 8'h03);
        chk("t6 restart", outs, {3'd2, 4'b1100});
        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            r          = int'($urandom_range(0, 3));
            rst        = $urandom_range(0, 199) == 0;
            start      = $urandom_range(0, 3) == 0;
            stop       = $urandom_range(0, 39) == 0;
            continuous = 1'($urandom_range(0, 1));
            dwell      = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
            skip_mask  = r == 0 ? 8'hFF : r == 1 ? ~(8'h01 << $urandom_range(0, 7)) : 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
